serial_word_assembler: RTL and testbench
========================================

Name: serial_word_assembler

Overview:
- Downstream consumer of the edge-triggered D flip-flop stage.
- Takes a clocked serial bit stream, already sampled by the D flip-flop, and assembles it into WIDTH-bit parallel words.
- Pulses a one-cycle valid strobe when each word completes.
- Feeds word-level logic such as comparators, counters and display decoders in later stages.

Parameters:
- WIDTH, 8: bits per word. Legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in pdata[WIDTH-1]; 0 = first received bit lands in pdata[0].
- CW, $clog2(WIDTH): width of the bit counter. Derived; never overridden.

Ports:
- clk  input  1  clock; every register updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  input  1  qualifies sin on this rising edge.
- clear  input  1  synchronous abort of the word in progress.
- pdata  output  WIDTH  last completed word; registered.
- pvalid  output  1  one-cycle strobe: pdata was updated on the previous edge.
- busy  output  1  high while a partial word is held (bit_cnt != 0).
- bit_cnt  output  CW  number of bits of the current word received so far.

Behaviour:
- Clock and reset:
  - One clock domain; all registers are rising-edge clk.
  - rst_n is asynchronous and active-low: on rst_n=0, sreg, bit_cnt, pdata and pvalid go to 0 immediately, independent of clk.
  - Reset release is synchronous in effect: the first edge with rst_n=1 behaves normally.
- Reset values: pdata=0, pvalid=0, busy=0, bit_cnt=0, internal shift register sreg=0.
- Per rising edge, priority order:
  1. clear=1: sreg<=0, bit_cnt<=0, pvalid<=0. pdata is retained. clear beats sin_valid on the same edge; that bit is discarded.
  2. sin_valid=1 and bit_cnt<WIDTH-1:
     - MSB_FIRST=1: sreg<={sreg[WIDTH-2:0],sin}.
     - MSB_FIRST=0: sreg<={sin,sreg[WIDTH-1:1]}.
     - bit_cnt<=bit_cnt+1; pvalid<=0.
  3. sin_valid=1 and bit_cnt==WIDTH-1 (final bit):
     - pdata<=the shifted value including this bit.
     - pvalid<=1; bit_cnt<=0; sreg<=0.
  4. sin_valid=0: hold sreg, bit_cnt and pdata; pvalid<=0.
- Latency: pdata and pvalid appear immediately after the edge that samples the WIDTH-th bit, i.e. zero extra cycles.
- pvalid is high for exactly one clk cycle per completed word, even if sin_valid drops afterwards.
- Gaps: sin_valid may deassert any number of cycles mid-word; assembly resumes without losing bits.
- Back-to-back words: the bit after a completed word is bit 0 of the next word. No idle cycle is required and none is inserted.
- busy is decoded combinationally from registered bit_cnt (no input-to-output combinational path).
- pdata changes only on word completion or reset. It is never partially updated.
- Reset mid-word: the partial word is lost, and no pvalid is emitted for it.
- Wrap-around: bit_cnt never exceeds WIDTH-1.
- X-safety: sin is ignored when sin_valid=0; sin=X with sin_valid=0 must not corrupt state.

Test Plan:
- WIDTH=8, MSB_FIRST=1, reset then send bits 1,0,1,0,0,1,0,1 on consecutive edges -> pdata=8'hA5, pvalid=1 for exactly one cycle after the 8th edge; bit_cnt counts 1..7 then 0; busy high during the word.
- MSB_FIRST=0, same bit sequence -> pdata=8'hA5 (first bit in pdata[0]).
- MSB_FIRST=1, send 8'h3C with sin_valid=0 for 3 cycles after bits 2 and 5 -> pdata=8'h3C; pvalid only after the 8th valid bit; bit_cnt holds during gaps.
- Back-to-back 8'h3C then 8'hC3 with no idle -> two pvalid pulses exactly 8 cycles apart; pdata=8'h3C then 8'hC3.
- Send 4 bits, assert clear together with sin_valid=1, then send 8'h5A -> no pvalid from the aborted word; pdata stays at its old value until 8'h5A completes, then pdata=8'h5A.
- Send 5 bits, pulse rst_n low between edges -> outputs zero immediately, before the next clk edge; next 8 bits 8'hFF -> pdata=8'hFF, single pvalid.

Source files
------------

// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Collects a qualified serial bit stream (already registered upstream) into
//   WIDTH-bit parallel words and strobes pvalid for one cycle per word.
//
// Ports
//   clk        rising-edge clock for every register
//   rst_n      asynchronous active-low reset
//   sin        serial data bit, used only when sin_valid=1
//   sin_valid  qualifies sin on this edge
//   clear      synchronous abort of the partial word (wins over sin_valid)
//   pdata      last completed word (registered, only updated on completion)
//   pvalid     one-cycle strobe: pdata was loaded on the previous edge
//   busy       a partial word is held (bit_cnt != 0)
//   bit_cnt    bits of the current word received so far
module serial_word_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  // Shift direction picks which end of the word the first bit ends up in.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign shifted = {sin, sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      pdata   <= '0;
      pvalid  <= 1'b0;
    end else if (clear) begin
      // Abort: the bit presented with clear is dropped, pdata kept.
      sreg    <= '0;
      bit_cnt <= '0;
      pvalid  <= 1'b0;
    end else if (sin_valid) begin
      if (bit_cnt == LAST) begin
        // Final bit goes straight into pdata so there is no extra latency;
        // sreg restarts empty so the next bit is bit 0 of the next word.
        pdata   <= shifted;
        pvalid  <= 1'b1;
        bit_cnt <= '0;
        sreg    <= '0;
      end else begin
        sreg    <= shifted;
        bit_cnt <= bit_cnt + 1'b1;
        pvalid  <= 1'b0;
      end
    end else begin
      pvalid <= 1'b0;
    end
  end

  assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

  logic       clk, rst_n, sin, sin_valid, clear;
  logic [7:0] pd_m, pd_l;
  logic       pv_m, pv_l, busy_m, busy_l;
  logic [2:0] cnt_m, cnt_l;

  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pdata(pd_m), .pvalid(pv_m), .busy(busy_m), .bit_cnt(cnt_m));

  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pdata(pd_l), .pvalid(pv_l), .busy(busy_l), .bit_cnt(cnt_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vec = 0;
  int         err = 0;
  int         mcnt = 0;
  bit         exp_pv = 1'b0;
  bit         mon_en = 1'b0;
  logic [7:0] last_m = 8'h00, last_l = 8'h00;
  logic [7:0] q_m[$], q_l[$];

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // One clock of stimulus; updates the bit-count model after the edge.
  task automatic drive(input logic v, input logic b, input logic c);
    sin_valid = v;
    sin       = v ? b : 1'bx;
    clear     = c;
    @(posedge clk); #1;
    if (c) begin
      mcnt = 0; exp_pv = 1'b0;
    end else if (v) begin
      mcnt++;
      exp_pv = (mcnt == 8);
      if (mcnt == 8) mcnt = 0;
    end else begin
      exp_pv = 1'b0;
    end
    sin_valid = 1'b0; sin = 1'bx; clear = 1'b0;
  endtask

  // Scoreboard: expected words queued when the word's first bit is driven.
  task automatic queue_word(input logic [7:0] w);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
  endtask

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      vec++;
      if (pv_m !== exp_pv || pv_l !== exp_pv) begin
        err++;
        $display("FAIL pvalid t=%0t got m=%b l=%b want %b", $time, pv_m, pv_l, exp_pv);
      end
      if (pv_m === 1'b1) begin
        if (q_m.size() == 0) begin
          err++; $display("FAIL pvalid_m_spurious t=%0t", $time);
        end else last_m = q_m.pop_front();
      end
      if (pv_l === 1'b1) begin
        if (q_l.size() == 0) begin
          err++; $display("FAIL pvalid_l_spurious t=%0t", $time);
        end else last_l = q_l.pop_front();
      end
      vec++;
      if (pd_m !== last_m || pd_l !== last_l) begin
        err++;
        $display("FAIL pdata t=%0t got m=%h l=%h want m=%h l=%h", $time, pd_m, pd_l, last_m, last_l);
      end
      vec++;
      if (cnt_m !== 3'(mcnt) || cnt_l !== 3'(mcnt) || busy_m !== (mcnt != 0) || busy_l !== (mcnt != 0)) begin
        err++;
        $display("FAIL bit_cnt/busy t=%0t got cnt=%0d/%0d busy=%b/%b want cnt=%0d", $time,
                 cnt_m, cnt_l, busy_m, busy_l, mcnt);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; sin = 1'bx; sin_valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (pd_m !== 8'h00 || pv_m !== 1'b0 || cnt_m !== 3'd0 || busy_m !== 1'b0 ||
        pd_l !== 8'h00 || pv_l !== 1'b0 || cnt_l !== 3'd0 || busy_l !== 1'b0) begin
      err++;
      $display("FAIL reset_state got pd=%h/%h pv=%b/%b cnt=%0d/%0d busy=%b/%b want zeros",
               pd_m, pd_l, pv_m, pv_l, cnt_m, cnt_l, busy_m, busy_l);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    queue_word(w);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[7-i], 1'b0);
      vec++;
      if (cnt_m !== 3'((i + 1) % 8) || busy_m !== (i != 7)) begin
        err++;
        $display("FAIL basic_count bit%0d got cnt=%0d busy=%b want cnt=%0d", i, cnt_m, busy_m, (i + 1) % 8);
      end
    end
    vec++;
    if (pd_m !== 8'hA5 || pd_l !== 8'hA5 || pv_m !== 1'b1 || pv_l !== 1'b1) begin
      err++;
      $display("FAIL basic_word got m=%h l=%h pv=%b/%b want a5 a5 1", pd_m, pd_l, pv_m, pv_l);
    end
    drive(1'b0, 1'b0, 1'b0);
    vec++;
    if (pv_m !== 1'b0 || pd_m !== 8'hA5) begin
      err++;
      $display("FAIL basic_pulse_width got pv=%b pd=%h want 0 a5", pv_m, pd_m);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h3C;
    queue_word(w);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[7-i], 1'b0);
      if (i == 1 || i == 4) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 1'b0);
          vec++;
          if (cnt_m !== 3'(i + 1) || pv_m !== 1'b0) begin
            err++;
            $display("FAIL gap_hold after bit%0d got cnt=%0d pv=%b want %0d 0", i, cnt_m, pv_m, i + 1);
          end
        end
      end
    end
    vec++;
    if (pd_m !== 8'h3C || pd_l !== rev8(8'h3C) || pv_m !== 1'b1) begin
      err++;
      $display("FAIL gap_word got m=%h l=%h pv=%b want 3c %h 1", pd_m, pd_l, pv_m, rev8(8'h3C));
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    int          p0, p1;
    s = 16'h3CC3;
    p0 = -1; p1 = -1;
    queue_word(8'h3C);
    queue_word(8'hC3);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, s[15-i], 1'b0);
      if (pv_m === 1'b1) begin
        if (p0 < 0) p0 = i; else p1 = i;
      end
      if (i == 7) begin
        vec++;
        if (pd_m !== 8'h3C) begin
          err++; $display("FAIL b2b_first got %h want 3c", pd_m);
        end
      end
    end
    vec++;
    if (p0 != 7 || p1 != 15 || pd_m !== 8'hC3) begin
      err++;
      $display("FAIL b2b_spacing got pulses at %0d,%0d pd=%h want 7,15 c3", p0, p1, pd_m);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    logic [7:0] w;
    for (int i = 0; i < 4; i++) drive(1'b1, i[0], 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    vec++;
    if (cnt_m !== 3'd0 || busy_m !== 1'b0 || pv_m !== 1'b0 || pd_m !== 8'hC3) begin
      err++;
      $display("FAIL clear_abort got cnt=%0d busy=%b pv=%b pd=%h want 0 0 0 c3", cnt_m, busy_m, pv_m, pd_m);
    end
    w = 8'h5A;
    queue_word(w);
    for (int i = 0; i < 8; i++) drive(1'b1, w[7-i], 1'b0);
    vec++;
    if (pd_m !== 8'h5A || pd_l !== rev8(8'h5A) || pv_m !== 1'b1) begin
      err++;
      $display("FAIL clear_next_word got m=%h l=%h pv=%b want 5a %h 1", pd_m, pd_l, pv_m, rev8(8'h5A));
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    vec++;
    if (pd_m !== 8'h00 || pv_m !== 1'b0 || cnt_m !== 3'd0 || busy_m !== 1'b0 || pd_l !== 8'h00) begin
      err++;
      $display("FAIL async_reset got pd=%h/%h pv=%b cnt=%0d busy=%b want zeros", pd_m, pd_l, pv_m, cnt_m, busy_m);
    end
    mcnt = 0; exp_pv = 1'b0; last_m = 8'h00; last_l = 8'h00;
    #1 rst_n = 1'b1;
    w = 8'hFF;
    queue_word(w);
    for (int i = 0; i < 8; i++) drive(1'b1, w[7-i], 1'b0);
    vec++;
    if (pd_m !== 8'hFF || pd_l !== 8'hFF || pv_m !== 1'b1) begin
      err++;
      $display("FAIL reset_next_word got m=%h l=%h pv=%b want ff ff 1", pd_m, pd_l, pv_m);
    end
    repeat (2) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    @(negedge clk);
    vec++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      err++;
      $display("FAIL scoreboard_drain got %0d/%0d words pending want 0", q_m.size(), q_l.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
